// File: rtl/cpu6_bus_responder.sv
// cpu6_bus_responder: CPU6 bus target with on-chip RAM and a MUX0 transmit-only serial port.
//   clock        in   system clock, rising edge
//   reset_n      in   asynchronous reset, active low
//   address      in   [15:0] bus address from CPU6
//   write_data   in   [7:0] bus write data from CPU6
//   write_enable in   write strobe, sampled on the rising edge
//   read_data    out  [7:0] registered read data to CPU6
//   uart_tx      out  8N1 serial output, idles high
//   tx_busy      out  high while a frame is on the wire
module cpu6_bus_responder #(
    parameter int          RAM_ADDR_BITS   = 12,
    parameter logic [15:0] MUX_BASE        = 16'hF200,
    parameter int          CLOCKS_PER_BIT  = 16,
    parameter int          FIFO_DEPTH_BITS = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [15:0] address,
    input  logic [7:0]  write_data,
    input  logic        write_enable,
    output logic [7:0]  read_data,
    output logic        uart_tx,
    output logic        tx_busy
);
    localparam int CW = $clog2(CLOCKS_PER_BIT);
    localparam int FB = FIFO_DEPTH_BITS;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state;
    logic [7:0]        ram [2**RAM_ADDR_BITS];
    logic [7:0]        fifo [2**FB];
    logic [FB:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]     bit_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift;
    logic              overflow;
    logic              in_ram, is_status, is_data, full, empty;
    logic              push_req, push, pop, bit_end;
    logic [7:0]        rd_next;

    always_comb begin
        in_ram    = address[15:RAM_ADDR_BITS] == '0;
        is_status = address == MUX_BASE;
        is_data   = address == MUX_BASE + 16'd1;
        empty     = wr_ptr == rd_ptr;
        // Pointers carry one extra bit so full and empty stay distinguishable.
        full      = (wr_ptr[FB] != rd_ptr[FB]) && (wr_ptr[FB-1:0] == rd_ptr[FB-1:0]);
        pop       = (state == IDLE) && !empty;
        push_req  = write_enable && is_data;
        push      = push_req && (!full || pop);
        bit_end   = bit_cnt == CW'(CLOCKS_PER_BIT - 1);
        rd_next   = in_ram    ? ram[address[RAM_ADDR_BITS-1:0]] :
                    is_status ? {overflow, 5'b0, !full, 1'b0} :
                    is_data   ? 8'h00 : 8'hFF;
    end

    // Storage arrays are not reset; the FIFO is flushed by resetting its pointers.
    always_ff @(posedge clock) begin
        if (write_enable && in_ram)
            ram[address[RAM_ADDR_BITS-1:0]] <= write_data;
        if (push)
            fifo[wr_ptr[FB-1:0]] <= write_data;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            read_data <= 8'h00;
            uart_tx   <= 1'b1;
            tx_busy   <= 1'b0;
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            overflow  <= 1'b0;
        end else begin
            read_data <= rd_next;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            // Status is sampled into read_data on the same edge that clears overflow.
            if (push_req && full && !pop)
                overflow <= 1'b1;
            else if (is_status && !write_enable)
                overflow <= 1'b0;
            bit_cnt <= (state == IDLE || bit_end) ? '0 : bit_cnt + 1'b1;
            case (state)
                IDLE: begin
                    uart_tx <= 1'b1;
                    if (pop) begin
                        shift   <= fifo[rd_ptr[FB-1:0]];
                        rd_ptr  <= rd_ptr + 1'b1;
                        uart_tx <= 1'b0;
                        tx_busy <= 1'b1;
                        state   <= START;
                    end
                end
                START: if (bit_end) begin
                    uart_tx <= shift[0];
                    shift   <= shift >> 1;
                    bit_idx <= '0;
                    state   <= DATA;
                end
                DATA: if (bit_end) begin
                    if (bit_idx == 3'd7) begin
                        uart_tx <= 1'b1;
                        state   <= STOP;
                    end else begin
                        uart_tx <= shift[0];
                        shift   <= shift >> 1;
                        bit_idx <= bit_idx + 1'b1;
                    end
                end
                STOP: if (bit_end) begin
                    tx_busy <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu6_bus_responder.sv
// tb_cpu6_bus_responder: directed self-checking bench for cpu6_bus_responder.
module tb_cpu6_bus_responder;
    logic        clock = 1'b0;
    logic        reset_n;
    logic [15:0] address;
    logic [7:0]  write_data;
    logic        write_enable;
    logic [7:0]  read_data;
    logic        uart_tx;
    logic        tx_busy;
    int          checks = 0;
    int          errors = 0;

    cpu6_bus_responder dut (
        .clock(clock),
        .reset_n(reset_n),
        .address(address),
        .write_data(write_data),
        .write_enable(write_enable),
        .read_data(read_data),
        .uart_tx(uart_tx),
        .tx_busy(tx_busy)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        address      = a;
        write_data   = d;
        write_enable = 1'b1;
        step();
        write_enable = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [15:0] a, input logic [7:0] exp);
        address = a;
        step();
        chk(tag, read_data, exp);
    endtask

    // Finds the start bit (bounded), then samples each bit near its middle.
    task automatic expect_frame(input string tag, input logic [7:0] b);
        logic [7:0] got;
        got = '0;
        for (int i = 0; i < 400 && uart_tx !== 1'b0; i++)
            step();
        chk1({tag, " start found"}, uart_tx, 1'b0);
        repeat (8) step();
        chk1({tag, " start mid"}, uart_tx, 1'b0);
        for (int i = 0; i < 8; i++) begin
            repeat (16) step();
            got[i] = uart_tx;
        end
        chk({tag, " data"}, got, b);
        repeat (16) step();
        chk1({tag, " stop"}, uart_tx, 1'b1);
    endtask

    initial begin
        logic [7:0] b;
        logic       exp_tx;
        logic       low_seen;
        reset_n      = 1'b0;
        address      = 16'h0000;
        write_data   = 8'h00;
        write_enable = 1'b0;
        #12;
        chk("reset read_data", read_data, 8'h00);
        chk1("reset uart_tx", uart_tx, 1'b1);
        chk1("reset tx_busy", tx_busy, 1'b0);
        reset_n = 1'b1;
        step();

        wr(16'h0124, 8'h3C);
        wr(16'h0123, 8'hA5);
        rd_chk("ram 0123", 16'h0123, 8'hA5);
        rd_chk("ram 0124 unchanged", 16'h0124, 8'h3C);

        wr(16'h0000, 8'h77);
        rd_chk("unmapped read", 16'h8000, 8'hFF);
        wr(16'h8000, 8'h99);
        rd_chk("unmapped after write", 16'h8000, 8'hFF);
        rd_chk("ram 0000 kept", 16'h0000, 8'h77);
        wr(16'hF200, 8'hFF);
        rd_chk("status idle", 16'hF200, 8'h02);
        rd_chk("mux data read", 16'hF201, 8'h00);

        wr(16'h0200, 8'h11);
        address      = 16'h0200;
        write_data   = 8'h22;
        write_enable = 1'b1;
        step();
        chk("read before write", read_data, 8'h11);
        write_enable = 1'b0;
        step();
        chk("read after write", read_data, 8'h22);

        b = 8'h55;
        wr(16'hF201, b);
        address = 16'h0000;
        chk1("push edge tx", uart_tx, 1'b1);
        chk1("push edge busy", tx_busy, 1'b0);
        for (int k = 0; k < 160; k++) begin
            step();
            exp_tx = (k < 16) ? 1'b0 : (k >= 144) ? 1'b1 : b[(k - 16) / 16];
            chk1($sformatf("frame55 tx k=%0d", k), uart_tx, exp_tx);
            chk1($sformatf("frame55 busy k=%0d", k), tx_busy, 1'b1);
        end
        step();
        chk1("frame55 end busy", tx_busy, 1'b0);
        chk1("frame55 end tx", uart_tx, 1'b1);

        for (int i = 0; i < 6; i++)
            wr(16'hF201, 8'h31 + 8'(i));
        address = 16'hF200;
        step();
        chk("status full overflow", read_data, 8'h80);
        step();
        chk("status overflow cleared", read_data, 8'h00);
        expect_frame("fifo0", 8'h31);
        expect_frame("fifo1", 8'h32);
        expect_frame("fifo2", 8'h33);
        expect_frame("fifo3", 8'h34);
        expect_frame("fifo4", 8'h35);
        low_seen = 1'b0;
        repeat (200) begin
            step();
            if (uart_tx !== 1'b1)
                low_seen = 1'b1;
        end
        chk1("dropped byte not sent", low_seen, 1'b0);
        rd_chk("status drained", 16'hF200, 8'h02);

        wr(16'hF201, 8'hA7);
        wr(16'hF201, 8'h5A);
        address = 16'h0000;
        repeat (69) step();
        chk1("mid bit3 busy", tx_busy, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk1("async reset tx", uart_tx, 1'b1);
        chk1("async reset busy", tx_busy, 1'b0);
        chk("async reset read_data", read_data, 8'h00);
        repeat (2) step();
        @(negedge clock);
        reset_n = 1'b1;
        rd_chk("status after reset", 16'hF200, 8'h02);
        low_seen = 1'b0;
        repeat (200) begin
            step();
            if (uart_tx !== 1'b1)
                low_seen = 1'b1;
        end
        chk1("no frame after reset", low_seen, 1'b0);
        chk1("idle busy after reset", tx_busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
